// File: rtl/eth_phy_10g_pkg.sv
// Shared constants and helpers for the 10GBASE-R PHY gearboxes.
//   BLOCK_WIDTH     : encoded block width (64b payload + 2b sync header)
//   WORD_WIDTH      : transceiver word width
//   GEARBOX_SEQ_MAX : last index of the 33-step gearbox sequence
//   SYNC_DATA/CTRL  : legal sync header values
package eth_phy_10g_pkg;

   localparam int BLOCK_WIDTH     = 66;
   localparam int WORD_WIDTH      = 64;
   localparam int GEARBOX_SEQ_MAX = 32;

   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;

   function automatic logic hdr_is_bad(input logic [1:0] hdr);
      return (hdr != SYNC_DATA) && (hdr != SYNC_CTRL);
   endfunction

   function automatic logic [WORD_WIDTH-1:0] bit_reverse64(input logic [WORD_WIDTH-1:0] w);
      logic [WORD_WIDTH-1:0] r;
      for (int i = 0; i < WORD_WIDTH; i++) begin
         r[i] = w[WORD_WIDTH-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/eth_phy_10g_gearbox_shift.sv
// Combinational funnel shifter for the 66:64 / 64:66 gearboxes.
// Places a 66-bit block above the r = 2*sel_i valid residual bits of buf_i
// and splits the result into a 64-bit word and the new residual.
//   block_i    : 66-bit block, bit 0 goes out first
//   buf_i      : residual bits, only [r-1:0] are used
//   sel_i      : sequence index 0..31, residual count is 2*sel_i
//   word_o     : combined[63:0]
//   residual_o : combined[r+65:64], zero-extended to 64 bits
module eth_phy_10g_gearbox_shift
   import eth_phy_10g_pkg::*;
(
   input  logic [BLOCK_WIDTH-1:0] block_i,
   input  logic [WORD_WIDTH-1:0]  buf_i,
   input  logic [4:0]             sel_i,
   output logic [WORD_WIDTH-1:0]  word_o,
   output logic [WORD_WIDTH-1:0]  residual_o
);

   logic [5:0]                 shamt;
   logic [WORD_WIDTH-1:0]      buf_mask;
   logic [2*WORD_WIDTH-1:0]    combined;

   always_comb begin
      // Residual count always moves in steps of two bits.
      shamt    = {sel_i, 1'b0};
      // Bits of buf_i above the residual count are don't-care; mask them so
      // they can never leak into the word.
      buf_mask = ~({WORD_WIDTH{1'b1}} << shamt);
      combined = ({{(2*WORD_WIDTH-BLOCK_WIDTH){1'b0}}, block_i} << shamt)
               | {{WORD_WIDTH{1'b0}}, buf_i & buf_mask};
   end

   assign word_o     = combined[WORD_WIDTH-1:0];
   assign residual_o = combined[2*WORD_WIDTH-1:WORD_WIDTH];

endmodule

// File: rtl/eth_phy_10g_tx_gearbox.sv
// 66:64 TX gearbox between the 10GBASE-R PCS and a 64-bit transceiver.
// 32 blocks are packed into 33 words over a fixed 33-cycle sequence; on the
// last step (seq 32) the PCS is paused and the 64 buffered bits are flushed.
//   clk                 : gearbox / PCS transmit clock
//   rst                 : asynchronous active-high reset
//   serdes_tx_data      : block payload from the PCS
//   serdes_tx_hdr       : sync header from the PCS
//   serdes_tx_pause     : PCS must hold its block this cycle
//   gearbox_tx_data     : word to transceiver, bit 0 first (or reversed)
//   gearbox_tx_sequence : sequence index of the word on gearbox_tx_data
//   tx_bad_hdr          : pulse, the accepted header was 00 or 11
module eth_phy_10g_tx_gearbox
   import eth_phy_10g_pkg::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int HDR_WIDTH   = 2,
   parameter int BIT_REVERSE = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] serdes_tx_data,
   input  logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
   output logic                  serdes_tx_pause,
   output logic [DATA_WIDTH-1:0] gearbox_tx_data,
   output logic [5:0]            gearbox_tx_sequence,
   output logic                  tx_bad_hdr
);

   logic [5:0]             seq_q, seq_d;
   logic [WORD_WIDTH-1:0]  buf_q, buf_d;
   logic [DATA_WIDTH-1:0]  data_q, data_d;
   logic [5:0]             seq_out_q, seq_out_d;
   logic                   bad_q, bad_d;

   logic                   pause;
   logic [BLOCK_WIDTH-1:0] block;
   logic [WORD_WIDTH-1:0]  shift_word;
   logic [WORD_WIDTH-1:0]  shift_residual;
   logic [WORD_WIDTH-1:0]  word;

   assign block = {serdes_tx_data, serdes_tx_hdr};
   // Decoded from the register alone so the PCS sees no input-to-pause path.
   assign pause = (seq_q == 6'(GEARBOX_SEQ_MAX));

   eth_phy_10g_gearbox_shift u_shift (
      .block_i    (block),
      .buf_i      (buf_q),
      .sel_i      (seq_q[4:0]),
      .word_o     (shift_word),
      .residual_o (shift_residual)
   );

   always_comb begin
      seq_d     = pause ? 6'd0 : seq_q + 6'd1;
      seq_out_d = seq_q;
      word      = shift_word;
      buf_d     = shift_residual;
      bad_d     = hdr_is_bad(serdes_tx_hdr);
      if (pause) begin
         // Residual holds exactly 64 bits here; input is ignored.
         word  = buf_q;
         buf_d = '0;
         bad_d = 1'b0;
      end
      data_d = (BIT_REVERSE != 0) ? bit_reverse64(word) : word;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seq_q     <= '0;
         buf_q     <= '0;
         data_q    <= '0;
         seq_out_q <= '0;
         bad_q     <= 1'b0;
      end else begin
         seq_q     <= seq_d;
         buf_q     <= buf_d;
         data_q    <= data_d;
         seq_out_q <= seq_out_d;
         bad_q     <= bad_d;
      end
   end

   assign serdes_tx_pause     = pause;
   assign gearbox_tx_data     = data_q;
   assign gearbox_tx_sequence = seq_out_q;
   assign tx_bad_hdr          = bad_q;

endmodule

// File: tb/tb_eth_phy_10g_tx_gearbox.sv
module tb_eth_phy_10g_tx_gearbox;

   typedef struct {
      logic [63:0] data;
      logic [5:0]  seq;
      logic        bad;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] serdes_tx_data = '0;
   logic [1:0]  serdes_tx_hdr  = 2'b01;
   logic        serdes_tx_pause;
   logic [63:0] gearbox_tx_data;
   logic [5:0]  gearbox_tx_sequence;
   logic        tx_bad_hdr;
   logic        pause_rev;
   logic [63:0] data_rev;
   logic [5:0]  seq_rev;
   logic        bad_rev;

   int vectors     = 0;
   int miscompares = 0;

   exp_t         sb_q[$];
   logic [127:0] acc = '0;
   int           cnt = 0;
   int           tb_seq = 0;
   int           cyc = 0;

   always #5 clk = ~clk;

   eth_phy_10g_tx_gearbox #(.DATA_WIDTH(64), .HDR_WIDTH(2), .BIT_REVERSE(0)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .serdes_tx_data      (serdes_tx_data),
      .serdes_tx_hdr       (serdes_tx_hdr),
      .serdes_tx_pause     (serdes_tx_pause),
      .gearbox_tx_data     (gearbox_tx_data),
      .gearbox_tx_sequence (gearbox_tx_sequence),
      .tx_bad_hdr          (tx_bad_hdr)
   );

   eth_phy_10g_tx_gearbox #(.DATA_WIDTH(64), .HDR_WIDTH(2), .BIT_REVERSE(1)) dut_rev (
      .clk                 (clk),
      .rst                 (rst),
      .serdes_tx_data      (serdes_tx_data),
      .serdes_tx_hdr       (serdes_tx_hdr),
      .serdes_tx_pause     (pause_rev),
      .gearbox_tx_data     (data_rev),
      .gearbox_tx_sequence (seq_rev),
      .tx_bad_hdr          (bad_rev)
   );

   function automatic logic [63:0] rev64(input logic [63:0] w);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[i] = w[63-i];
      return r;
   endfunction

   // Bit-accumulator model: append 66 bits, emit every full 64-bit word.
   task automatic model_accept(input logic [63:0] d, input logic [1:0] h);
      logic [65:0] blk;
      int          k;
      exp_t        e;
      blk = {d, h};
      acc = acc | ({62'd0, blk} << cnt);
      cnt = cnt + 66;
      k = 0;
      while (cnt >= 64) begin
         e.data = acc[63:0];
         e.seq  = 6'(tb_seq + k);
         e.bad  = (k == 0) && (h == 2'b00 || h == 2'b11);
         sb_q.push_back(e);
         acc = acc >> 64;
         cnt = cnt - 64;
         k++;
      end
   endtask

   task automatic model_clear();
      sb_q.delete();
      acc    = '0;
      cnt    = 0;
      tb_seq = 0;
      cyc    = 0;
   endtask

   // Entered and left just after a falling edge.
   task automatic cycle(input logic [63:0] d, input logic [1:0] h, output logic [63:0] obs);
      exp_t e;
      vectors++;
      if (serdes_tx_pause !== (tb_seq == 32) || pause_rev !== (tb_seq == 32)) begin
         miscompares++;
         $display("FAIL pause seq=%0d got %b/%b want %b", tb_seq, serdes_tx_pause, pause_rev, tb_seq == 32);
      end
      serdes_tx_data = d;
      serdes_tx_hdr  = h;
      if (tb_seq != 32) model_accept(d, h);
      @(posedge clk);
      tb_seq = (tb_seq == 32) ? 0 : tb_seq + 1;
      cyc++;
      @(negedge clk);
      obs = gearbox_tx_data;
      vectors++;
      if (sb_q.size() == 0) begin
         miscompares++;
         $display("FAIL scoreboard_empty got %h want <queued word>", gearbox_tx_data);
      end else begin
         e = sb_q.pop_front();
         if (gearbox_tx_data !== e.data) begin
            miscompares++;
            $display("FAIL word got %h want %h", gearbox_tx_data, e.data);
         end
         vectors++;
         if (gearbox_tx_sequence !== e.seq || seq_rev !== e.seq) begin
            miscompares++;
            $display("FAIL sequence got %0d/%0d want %0d", gearbox_tx_sequence, seq_rev, e.seq);
         end
         vectors++;
         if (tx_bad_hdr !== e.bad || bad_rev !== e.bad) begin
            miscompares++;
            $display("FAIL bad_hdr got %b/%b want %b", tx_bad_hdr, bad_rev, e.bad);
         end
         vectors++;
         if (data_rev !== rev64(e.data)) begin
            miscompares++;
            $display("FAIL reversed_word got %h want %h", data_rev, rev64(e.data));
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   task automatic rand_block(output logic [63:0] d, output logic [1:0] h);
      d = {$urandom, $urandom};
      h = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
   endtask

   task automatic check_zero(input string tag);
      vectors++;
      if (gearbox_tx_data !== 64'd0 || data_rev !== 64'd0 || gearbox_tx_sequence !== 6'd0 ||
          tx_bad_hdr !== 1'b0 || serdes_tx_pause !== 1'b0) begin
         miscompares++;
         $display("FAIL %s got data=%h seq=%0d bad=%b pause=%b want all zero",
                  tag, gearbox_tx_data, gearbox_tx_sequence, tx_bad_hdr, serdes_tx_pause);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_zero("reset_during");
      repeat (5) @(negedge clk);
      check_zero("reset_held");
      rst = 1'b0;
      model_clear();
      #1;
      check_zero("reset_release");
      @(negedge clk);
   endtask

   task automatic test_cadence();
      int          found[$];
      int          want[3];
      logic [63:0] d, obs;
      logic [1:0]  h;
      want[0] = 32; want[1] = 65; want[2] = 98;
      do_reset();
      for (int i = 0; i < 100; i++) begin
         if (serdes_tx_pause === 1'b1) found.push_back(cyc);
         rand_block(d, h);
         cycle(d, h, obs);
      end
      vectors++;
      if (found.size() != 3) begin
         miscompares++;
         $display("FAIL cadence_count got %0d want 3", found.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (found[i] != want[i]) begin
               miscompares++;
               $display("FAIL cadence_pos got %0d want %0d", found[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_packing();
      logic [63:0] words[33];
      logic [63:0] d, obs;
      do_reset();
      for (int k = 0; k < 33; k++) begin
         d = (k < 32) ? 64'(k) * 64'h0101010101010101 : 64'd0;
         cycle(d, 2'b01, obs);
         words[k] = obs;
      end
      vectors++;
      if (words[0] !== 64'h0000000000000001) begin
         miscompares++;
         $display("FAIL packing_word0 got %h want %h", words[0], 64'h1);
      end
      vectors++;
      if (words[32] !== 64'h1f1f1f1f1f1f1f1f) begin
         miscompares++;
         $display("FAIL packing_word32 got %h want %h", words[32], 64'h1f1f1f1f1f1f1f1f);
      end
   endtask

   task automatic test_pause_ignore();
      logic [63:0] d, obs;
      logic [1:0]  h;
      int          pulses = 0;
      for (int k = 0; k < 33; k++) begin
         rand_block(d, h);
         if (tb_seq == 32) begin
            d = 64'hDEADBEEF_DEADBEEF;
            h = 2'b11;
         end
         cycle(d, h, obs);
         if (tx_bad_hdr === 1'b1) pulses++;
      end
      vectors++;
      if (pulses != 0) begin
         miscompares++;
         $display("FAIL pause_ignore_bad got %0d pulses want 0", pulses);
      end
   endtask

   task automatic test_bad_hdr();
      logic [63:0] d, obs;
      logic [1:0]  h;
      int          pulses = 0;
      int          pulse_seq = -1;
      for (int k = 0; k < 33; k++) begin
         rand_block(d, h);
         if (tb_seq == 5) begin
            d = 64'hA5A5_0F0F_C3C3_1234;
            h = 2'b00;
         end
         cycle(d, h, obs);
         if (tx_bad_hdr === 1'b1) begin
            pulses++;
            pulse_seq = int'(gearbox_tx_sequence);
         end
      end
      vectors++;
      if (pulses != 1 || pulse_seq != 5) begin
         miscompares++;
         $display("FAIL bad_hdr_pulse got %0d pulses at label %0d want 1 at 5", pulses, pulse_seq);
      end
   endtask

   task automatic test_mid_reset();
      logic [63:0] d, obs;
      logic [1:0]  h;
      do_reset();
      while (tb_seq != 17) begin
         rand_block(d, h);
         cycle(d, h, obs);
      end
      #2;
      rst = 1'b1;
      #1;
      check_zero("mid_reset_async");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_clear();
      cycle(64'h1234_5678_9ABC_DEF0, 2'b10, obs);
      vectors++;
      if (obs !== {64'h1234_5678_9ABC_DEF0 << 2} + 64'd2) begin
         miscompares++;
         $display("FAIL mid_reset_first_word got %h want %h", obs, (64'h1234_5678_9ABC_DEF0 << 2) + 64'd2);
      end
      for (int k = 1; k < 33; k++) begin
         rand_block(d, h);
         cycle(d, h, obs);
      end
   endtask

   initial begin
      test_reset();
      test_cadence();
      test_packing();
      test_pause_ignore();
      test_bad_hdr();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/eth_phy_10g_tx_gearbox.md
Name: eth_phy_10g_tx_gearbox

Overview:
- 66:64 synchronous TX gearbox between the 10GBASE-R PCS transmit output (serdes_tx_data/serdes_tx_hdr) and a 64-bit transceiver user interface that has no native 66b support.
- Packs 32 encoded 66-bit blocks into 33 64-bit words in a fixed 33-cycle sequence.
- Stalls the upstream PCS for one cycle in every 33 via a pause output.
- Single clock domain, same clock as the PCS transmit side.

Parameters:
- DATA_WIDTH, 64, PCS data width; only 64 is supported.
- HDR_WIDTH, 2, sync header width; only 2 is supported.
- BIT_REVERSE, 0, when 1, bit-reverses each 64-bit output word (MSB-first transceivers).

Ports:
- clk  input  1  gearbox clock (transceiver user clock).
- rst  input  1  asynchronous active-high reset.
- serdes_tx_data  input  DATA_WIDTH  encoded block payload from the PCS.
- serdes_tx_hdr  input  HDR_WIDTH  sync header from the PCS (01 data, 10 control).
- serdes_tx_pause  output  1  high means the input block is not consumed this cycle and the PCS must hold.
- gearbox_tx_data  output  DATA_WIDTH  word to the transceiver, bit 0 transmitted first.
- gearbox_tx_sequence  output  6  current sequence index, 0..32.
- tx_bad_hdr  output  1  one-cycle pulse, an accepted header was 00 or 11.

Behaviour:
- Interface: clock and reset are `clk` and `rst`. Reset is asynchronous, active-high. Everything is in one clock domain.
- Reset values: seq=0, residual count r=0, residual buffer=0, gearbox_tx_data=0, tx_bad_hdr=0. serdes_tx_pause=0 because seq=0.
- Block format: block = {serdes_tx_data, serdes_tx_hdr}, 66 bits, header in bits [1:0], so the header is transmitted first.
- Accept cycle (seq 0..31):
  - Block is accepted; serdes_tx_pause=0.
  - r = 2*seq residual bits are held in buf[r-1:0].
  - Form combined = {block, buf[r-1:0]}, width r+66.
  - Register gearbox_tx_data <= combined[63:0].
  - buf <= combined[r+65:64]; r <= r+2.
- Pause cycle (seq 32):
  - serdes_tx_pause=1; r=64.
  - Input is ignored, whatever its value.
  - gearbox_tx_data <= buf[63:0]; r <= 0.
- Sequence counter: seq increments every cycle and wraps 32 -> 0. No other state. Period is exactly 33 cycles.
- Pause timing: serdes_tx_pause = (seq==32), decoded from the seq register only (no combinational path from the inputs). The PCS must present the same block again on the cycle after the pause.
- Latency: one clock from block acceptance to the word that carries its first bit.
- Word-count invariant: 32 blocks × 66 bits = 33 words × 64 bits. Words 0..32 of a period are the exact LSB-first concatenation of blocks 0..31.
- gearbox_tx_sequence: the seq value registered alongside gearbox_tx_data, so it labels the word currently on the output.
- tx_bad_hdr: registered; asserted the cycle after an accept cycle whose hdr is 00 or 11. Never asserted for a pause cycle. The block is still passed through unchanged.
- BIT_REVERSE=1: gearbox_tx_data[i] = word[63-i]. Applied at the output register only.
- Mid-operation reset: all state clears immediately (asynchronous), and the next period starts at seq=0 after deassertion. Blocks in flight are discarded, with no partial-word flush.
- Word widths: residual buffer ≤ 64 bits; combined ≤ 128 bits. Shift selection uses seq (0..31) as a 5-bit index into a 2-bit-granular mux.

Decomposition:
- Shared package eth_phy_10g_pkg holds:
  - BLOCK_WIDTH=66;
  - GEARBOX_SEQ_MAX=32;
  - SYNC_DATA=2'b01 and SYNC_CTRL=2'b10.
- One natural sub-module, eth_phy_10g_gearbox_shift: a combinational funnel shifter that takes {block, buf} and r and returns the output word and the new residual. It is reused later by the RX 64:66 gearbox.

Test Plan:
- Reset: hold rst 5 cycles, then release → gearbox_tx_data=0, seq=0, pause=0, tx_bad_hdr=0 during and immediately after reset.
- Cadence: free-run 100 cycles → pause high exactly at cycles 32, 65, 98 after reset release; gearbox_tx_sequence wraps 32→0.
- Packing: feed block k = {64'h0101010101010101*k, 2'b01} for k=0..31 → the 33 output words equal the LSB-first concatenation; word 0 = {data0[61:0], 2'b01}; word 32 = data31[63:0].
- Pause ignore: drive 64'hDEADBEEF_DEADBEEF with hdr 11 on the pause cycle only → output stream unchanged and tx_bad_hdr stays 0.
- Bad header: present hdr=2'b00 on seq 5 → tx_bad_hdr pulses for one cycle at seq-register 6, and the bits appear unmodified in the stream.
- Mid-sequence reset: assert rst at seq 17 → outputs zero asynchronously; after release, seq restarts at 0 and the first word = new block 0 [63:0] with no stale residual.
